// File: rtl/mna_pkg.sv
// Shared definitions for the master-side NoC flit serializer:
// flit type codes, FSM states and flit field positions.
package mna_pkg;

    localparam int TYPE_W = 2;

    localparam logic [TYPE_W-1:0] FLIT_INVALID = 2'b00;
    localparam logic [TYPE_W-1:0] FLIT_HEAD    = 2'b01;
    localparam logic [TYPE_W-1:0] FLIT_BODY    = 2'b10;
    localparam logic [TYPE_W-1:0] FLIT_TAIL    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEAD,
        ST_BODY,
        ST_TAIL
    } state_t;

    // A single-VC network still carries a 1-bit VC field.
    function automatic int vc_width(input int num_vc);
        return (num_vc > 1) ? $clog2(num_vc) : 1;
    endfunction

    // Flit layout is {type, vc, payload}, payload at bit 0.
    function automatic int type_lsb(input int vc_w, input int payload_w);
        return vc_w + payload_w;
    endfunction

    function automatic int vc_lsb(input int payload_w);
        return payload_w;
    endfunction

    function automatic int tail_write_bit(input int payload_w);
        return payload_w - 1;
    endfunction

endpackage

// File: rtl/mna_rr_vc_arbiter.sv
// Round-robin virtual-channel picker: grants the lowest free VC at or
// after the pointer (wrapping), and moves the pointer past it on advance.
module mna_rr_vc_arbiter
    import mna_pkg::*;
#(
    parameter  int NUM_VC = 8,
    localparam int VC_W   = vc_width(NUM_VC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_VC-1:0] req_i,
    input  logic              advance_i,
    output logic [VC_W-1:0]   grant_idx_o,
    output logic              grant_valid_o
);

    localparam logic [VC_W-1:0] LAST_VC = VC_W'(NUM_VC - 1);

    logic [VC_W-1:0] ptr_q;
    logic [VC_W-1:0] ptr_d;
    logic [VC_W-1:0] cand;

    // Scan from the farthest offset down so the nearest free VC wins.
    // NOTE: every variable written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        cand          = '0;
        for (int k = NUM_VC - 1; k >= 0; k--) begin
            cand = VC_W'((int'(ptr_q) + k) % NUM_VC);
            if (req_i[cand]) begin
                grant_idx_o   = cand;
                grant_valid_o = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && grant_valid_o) begin
            ptr_d = (grant_idx_o == LAST_VC) ? '0 : grant_idx_o + VC_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mna_flit_serializer.sv
// Takes one AXI4-Lite-derived request at a time, claims a free VC
// round-robin, and emits head / body... / tail flits under backpressure.
module mna_flit_serializer
    import mna_pkg::*;
#(
    parameter  int NUM_VC    = 8,
    parameter  int PAYLOAD_W = 32,
    parameter  int DATA_W    = 32,
    localparam int VC_W      = vc_width(NUM_VC),
    localparam int STRB_W    = DATA_W / 8,
    localparam int FLIT_W    = TYPE_W + VC_W + PAYLOAD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [STRB_W-1:0] req_wstrb,
    input  logic [NUM_VC-1:0] vc_allocatable,
    output logic [FLIT_W-1:0] flit_out,
    output logic              flit_valid,
    input  logic              flit_ready,
    output logic              busy
);

    localparam int NB          = DATA_W / PAYLOAD_W;
    localparam int BEAT_W      = (NB > 1) ? $clog2(NB) : 1;
    localparam int TAIL_WR_BIT = tail_write_bit(PAYLOAD_W);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NB - 1);

    state_t              state_q, state_d;
    logic [FLIT_W-1:0]   flit_q, flit_d;
    logic                flit_valid_q, flit_valid_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;

    logic                write_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic [VC_W-1:0]     vc_q;

    logic [VC_W-1:0]     grant_idx;
    logic                grant_valid;
    logic                accept;
    logic                fire;
    logic [BEAT_W-1:0]   body_idx;
    logic [PAYLOAD_W-1:0] head_payload;
    logic [PAYLOAD_W-1:0] body_payload;
    logic [PAYLOAD_W-1:0] tail_payload;

    mna_rr_vc_arbiter #(
        .NUM_VC (NUM_VC)
    ) u_arb (
        .clk           (clk),
        .rst           (rst),
        .req_i         (vc_allocatable),
        .advance_i     (accept),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (grant_valid)
    );

    // grant_valid is exactly |vc_allocatable, so readiness never waits on req_valid.
    assign req_ready = (state_q == ST_IDLE) && grant_valid;
    assign accept    = req_valid && req_ready;
    assign fire      = flit_valid_q && flit_ready;

    // The body index is the slice that follows the flit now on the wire.
    assign body_idx     = (state_q == ST_HEAD) ? '0 : beat_q + BEAT_W'(1);
    assign head_payload = PAYLOAD_W'(req_addr);
    assign body_payload = PAYLOAD_W'(wdata_q >> (PAYLOAD_W * int'(body_idx)));

    always_comb begin
        tail_payload              = '0;
        tail_payload[TAIL_WR_BIT] = write_q;
        if (write_q) begin
            tail_payload[STRB_W-1:0] = wstrb_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = ST_HEAD;
            ST_HEAD: if (fire)   state_d = write_q ? ST_BODY : ST_TAIL;
            ST_BODY: if (fire && beat_q == LAST_BEAT) state_d = ST_TAIL;
            ST_TAIL: if (fire)   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Next registered flit: each handshake loads the following flit, so the
    // wire carries one flit per cycle with no bubbles.
    always_comb begin
        flit_d       = flit_q;
        flit_valid_d = flit_valid_q;
        beat_d       = beat_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    flit_d       = {FLIT_HEAD, grant_idx, head_payload};
                    flit_valid_d = 1'b1;
                    beat_d       = '0;
                end
            end
            ST_HEAD: begin
                if (fire) begin
                    flit_d = write_q ? {FLIT_BODY, vc_q, body_payload}
                                     : {FLIT_TAIL, vc_q, tail_payload};
                end
            end
            ST_BODY: begin
                if (fire) begin
                    if (beat_q == LAST_BEAT) begin
                        flit_d = {FLIT_TAIL, vc_q, tail_payload};
                    end else begin
                        flit_d = {FLIT_BODY, vc_q, body_payload};
                        beat_d = body_idx;
                    end
                end
            end
            ST_TAIL: begin
                if (fire) begin
                    flit_d       = {FLIT_INVALID, {(FLIT_W - TYPE_W){1'b0}}};
                    flit_valid_d = 1'b0;
                end
            end
            default: begin
                flit_d       = '0;
                flit_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flit_q       <= '0;
            flit_valid_q <= 1'b0;
            beat_q       <= '0;
        end else begin
            flit_q       <= flit_d;
            flit_valid_q <= flit_valid_d;
            beat_q       <= beat_d;
        end
    end

    // NOTE: request payload registers carry no reset; they are only read
    // while the FSM is past IDLE, which guarantees a prior load.
    always_ff @(posedge clk) begin
        if (accept) begin
            write_q <= req_write;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
            vc_q    <= grant_idx;
        end
    end

    assign flit_out   = flit_q;
    assign flit_valid = flit_valid_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mna_flit_serializer.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// against a packet-level queue model of the serializer.
module tb_mna_flit_serializer;

    logic        clk = 1'b0;
    logic        rst;

    // default instance (DATA_W = PAYLOAD_W = 32)
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic [7:0]  vc_allocatable;
    logic [36:0] flit_out;
    logic        flit_valid, flit_ready, busy;

    // wide instance (DATA_W = 64)
    logic        r_valid, r_ready, r_write;
    logic [31:0] r_addr;
    logic [63:0] r_wdata;
    logic [7:0]  r_wstrb;
    logic [7:0]  r_vc;
    logic [36:0] r_flit;
    logic        r_fvalid, r_fready, r_busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [36:0] exp_q[$];
    logic [36:0] obs_flit[$];
    int          obs_cyc[$];
    int          model_rr = 0;
    bit          mon_en   = 1'b0;
    bit          rand_mode = 1'b0;
    bit          stall_q  = 1'b0;
    logic [36:0] prev_flit = '0;

    mna_flit_serializer dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_wstrb      (req_wstrb),
        .vc_allocatable (vc_allocatable),
        .flit_out       (flit_out),
        .flit_valid     (flit_valid),
        .flit_ready     (flit_ready),
        .busy           (busy)
    );

    mna_flit_serializer #(.PAYLOAD_W(32), .DATA_W(64)) dut64 (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (r_valid),
        .req_ready      (r_ready),
        .req_write      (r_write),
        .req_addr       (r_addr),
        .req_wdata      (r_wdata),
        .req_wstrb      (r_wstrb),
        .vc_allocatable (r_vc),
        .flit_out       (r_flit),
        .flit_valid     (r_fvalid),
        .flit_ready     (r_fready),
        .busy           (r_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [36:0] get_obs(input int i);
        if (i < obs_flit.size()) return obs_flit[i];
        return '1;
    endfunction

    function automatic int get_cyc(input int i);
        if (i < obs_cyc.size()) return obs_cyc[i];
        return -100;
    endfunction

    // Model: first free VC at or after the pointer, modulo 8.
    function automatic int pick_vc(input logic [7:0] alloc);
        for (int k = 0; k < 8; k++) begin
            if (alloc[(model_rr + k) % 8]) return (model_rr + k) % 8;
        end
        return -1;
    endfunction

    // Packet-level monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            check("busy", busy, exp_q.size() != 0);
            check("flit_valid", flit_valid, exp_q.size() != 0);
            check("req_ready", req_ready, (exp_q.size() == 0) && (vc_allocatable != 0));
            if (stall_q) check("hold", flit_out, prev_flit);
            if (flit_valid && flit_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_flit", flit_out, 37'h0);
                end else begin
                    check("flit", flit_out, exp_q.pop_front());
                    obs_flit.push_back(flit_out);
                    obs_cyc.push_back(cyc);
                end
            end
            stall_q   = flit_valid && !flit_ready;
            prev_flit = flit_out;
        end
    end

    // Random flit_ready / vc_allocatable churn during the random phase.
    always @(posedge clk) begin
        #1;
        if (rand_mode) begin
            flit_ready     = ($urandom_range(0, 9) < 7);
            vc_allocatable = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
        end
    end

    // Called and returns at posedge+1. Expected flits are queued just after
    // the accepting edge.
    task automatic send_req(input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] s);
        bit done = 1'b0;
        int vc;
        req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
        req_valid = 1'b1;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            if (req_ready) begin
                vc = pick_vc(vc_allocatable);
                model_rr = (vc + 1) % 8;
                @(posedge clk); #1;
                exp_q.push_back({2'b01, 3'(vc), a});
                if (w) exp_q.push_back({2'b10, 3'(vc), d});
                exp_q.push_back({2'b11, 3'(vc), w, 27'd0, (w ? s : 4'd0)});
                req_valid = 1'b0;
                done = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!done) begin
            req_valid = 1'b0;
            check("accept_timeout", done, 1'b1);
        end
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int t = 0; t < 500 && !idle; t++) begin
            @(posedge clk); #1;
            idle = (exp_q.size() == 0);
        end
        check("idle_timeout", idle, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        vc_allocatable = 8'hFF; flit_ready = 1'b1;
        r_valid = 1'b0; r_write = 1'b0; r_addr = '0; r_wdata = '0; r_wstrb = '0;
        r_vc = 8'hFF; r_fready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;

        // Reset values
        @(negedge clk);
        check("rst_flit_valid", flit_valid, 1'b0);
        check("rst_flit_out", flit_out, 37'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_req_ready", req_ready, 1'b1);
        @(posedge clk); #1;

        // Read after reset: VC 0, then VC 1
        obs_flit.delete(); obs_cyc.delete();
        send_req(1'b0, 32'h4000_0010, 32'hDEAD_BEEF, 4'hA);
        wait_idle();
        check("rd_head", get_obs(0), 37'h08_4000_0010);
        check("rd_tail", get_obs(1), 37'h18_0000_0000);
        check("rd_tail_next", get_cyc(1) - get_cyc(0), 1);
        send_req(1'b0, 32'h0000_0020, 32'h0, 4'h0);
        wait_idle();
        check("rd2_vc", get_obs(2) >> 32, 5'b01_001);

        // Single free VC 7: write addr 0, wdata 1, wstrb F
        obs_flit.delete(); obs_cyc.delete();
        vc_allocatable = 8'b1000_0000;
        send_req(1'b1, 32'h0, 32'h1, 4'hF);
        wait_idle();
        check("wr_count", obs_flit.size(), 3);
        check("wr_head", get_obs(0), 37'h0F_0000_0000);
        check("wr_body", get_obs(1), 37'h17_0000_0001);
        check("wr_tail", get_obs(2), 37'h1F_8000_000F);
        check("wr_consec", get_cyc(2) - get_cyc(0), 2);

        // Round-robin wrap: pointer to 7, then VC 0 then VC 2
        vc_allocatable = 8'b0100_0000;
        send_req(1'b0, 32'h100, 32'h0, 4'h0);
        wait_idle();
        obs_flit.delete(); obs_cyc.delete();
        vc_allocatable = 8'b0000_0101;
        send_req(1'b0, 32'h104, 32'h0, 4'h0);
        wait_idle();
        send_req(1'b0, 32'h108, 32'h0, 4'h0);
        wait_idle();
        check("wrap_vc0", get_obs(0) >> 32, 5'b01_000);
        check("wrap_vc2", get_obs(2) >> 32, 5'b01_010);

        // Backpressure: hold the body flit for 5 cycles
        obs_flit.delete(); obs_cyc.delete();
        vc_allocatable = 8'hFF;
        send_req(1'b1, 32'h0000_0200, 32'hCAFE_F00D, 4'h3);
        @(posedge clk); #1;
        flit_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("bp_is_body", flit_out[36:35], 2'b10);
            @(posedge clk); #1;
        end
        flit_ready = 1'b1;
        wait_idle();
        check("bp_count", obs_flit.size(), 3);
        check("bp_tail_after", get_cyc(2) - get_cyc(1), 1);
        check("bp_body_wait", get_cyc(1) - get_cyc(0), 6);

        // No VC free: request must wait with no flits
        vc_allocatable = 8'h00;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h300; req_wdata = 32'h5; req_wstrb = 4'h1;
        repeat (5) begin
            @(negedge clk);
            check("novc_ready", req_ready, 1'b0);
            check("novc_valid", flit_valid, 1'b0);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        vc_allocatable = 8'hFF;

        // Reset during the body flit drops the packet
        send_req(1'b1, 32'h400, 32'h1234_5678, 4'hC);
        @(posedge clk); #1;
        flit_ready = 1'b0;
        @(negedge clk);
        check("mid_is_body", flit_out[36:35], 2'b10);
        mon_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("mid_pre_busy", busy, 1'b1);
        @(negedge clk);
        check("mid_rst_valid", flit_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_flit", flit_out, 37'h0);
        check("mid_rst_ready", req_ready, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        model_rr = 0;
        stall_q = 1'b0;
        flit_ready = 1'b1;
        mon_en = 1'b1;

        // Wide instance: two body slices, least significant first
        r_write = 1'b1; r_addr = 32'h0000_1000;
        r_wdata = 64'h1122_3344_5566_7788; r_wstrb = 8'hFF;
        r_valid = 1'b1;
        @(negedge clk);
        check("w64_ready", r_ready, 1'b1);
        @(posedge clk); #1;
        r_valid = 1'b0;
        begin
            logic [36:0] w64_exp [4];
            w64_exp[0] = 37'h08_0000_1000;
            w64_exp[1] = 37'h10_5566_7788;
            w64_exp[2] = 37'h10_1122_3344;
            w64_exp[3] = 37'h18_8000_00FF;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                check("w64_valid", r_fvalid, 1'b1);
                check("w64_flit", r_flit, w64_exp[i]);
            end
        end
        @(negedge clk);
        check("w64_done_valid", r_fvalid, 1'b0);
        check("w64_done_busy", r_busy, 1'b0);
        @(posedge clk); #1;

        // Randomized traffic with random backpressure and VC churn
        rand_mode = 1'b1;
        repeat (80) begin
            send_req(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        rand_mode = 1'b0;
        flit_ready = 1'b1;
        vc_allocatable = 8'hFF;
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
